// File: rtl/ibex_irq_sync.sv
// Interrupt front-end: synchronises raw SoC interrupt lines into the core clock domain,
// latches edge-triggered fast interrupts and sequences the NMI request towards the controller.
module ibex_irq_sync #(
    parameter int unsigned SyncStages   = 2,
    parameter logic [14:0] FastEdgeMask = 15'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        irq_software_raw_i,
    input  logic        irq_timer_raw_i,
    input  logic        irq_external_raw_i,
    input  logic [14:0] irq_fast_raw_i,
    input  logic        irq_nmi_raw_i,
    input  logic [14:0] irq_fast_clr_i,
    input  logic        nmi_ack_i,
    input  logic        nmi_mode_i,
    output logic        irq_software_o,
    output logic        irq_timer_o,
    output logic        irq_external_o,
    output logic [14:0] irq_fast_o,
    output logic        irq_nmi_o,
    output logic        nmi_lost_o
);

    localparam int unsigned NumLines = 19;

    typedef enum logic [1:0] {
        NMI_IDLE,
        NMI_PEND,
        NMI_ACTIVE
    } nmi_state_e;

    logic [NumLines-1:0]                  raw_all;
    logic [SyncStages-1:0][NumLines-1:0]  sync_q;
    logic [NumLines-1:0]                  sync;
    logic [14:0]                          fast_sync;
    logic [14:0]                          fast_hist_q;
    logic [14:0]                          fast_edge;
    logic [14:0]                          fast_pend_q;
    logic                                 nmi_sync;
    logic                                 nmi_hist_q;
    logic                                 nmi_edge;
    nmi_state_e                           nmi_state_q;
    logic                                 nmi_queued_q;
    logic                                 mode_seen_q;

    // Bit layout shared by every synchroniser stage: {nmi, fast[14:0], external, timer, software}
    assign raw_all = {irq_nmi_raw_i, irq_fast_raw_i, irq_external_raw_i,
                      irq_timer_raw_i, irq_software_raw_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], raw_all};
        end
    end

    assign sync      = sync_q[SyncStages-1];
    assign fast_sync = sync[17:3];
    assign nmi_sync  = sync[18];

    assign irq_software_o = sync[0];
    assign irq_timer_o    = sync[1];
    assign irq_external_o = sync[2];

    assign fast_edge = fast_sync & ~fast_hist_q & FastEdgeMask;
    assign nmi_edge  = nmi_sync & ~nmi_hist_q;

    // A rising edge outranks a clear arriving in the same cycle, so no interrupt is lost
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fast_hist_q <= '0;
            fast_pend_q <= '0;
            nmi_hist_q  <= 1'b0;
        end else begin
            fast_hist_q <= fast_sync;
            fast_pend_q <= ((fast_pend_q & ~irq_fast_clr_i) | fast_edge) & FastEdgeMask;
            nmi_hist_q  <= nmi_sync;
        end
    end

    assign irq_fast_o = (fast_pend_q & FastEdgeMask) | (fast_sync & ~FastEdgeMask);

    // An edge arriving in the very cycle the handler finishes is folded into the re-request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nmi_state_q  <= NMI_IDLE;
            nmi_queued_q <= 1'b0;
            mode_seen_q  <= 1'b0;
            irq_nmi_o    <= 1'b0;
            nmi_lost_o   <= 1'b0;
        end else begin
            nmi_lost_o <= 1'b0;
            case (nmi_state_q)
                NMI_IDLE: begin
                    if (nmi_edge) begin
                        nmi_state_q <= NMI_PEND;
                        irq_nmi_o   <= 1'b1;
                    end
                end
                NMI_PEND: begin
                    if (nmi_ack_i) begin
                        nmi_state_q  <= NMI_ACTIVE;
                        irq_nmi_o    <= 1'b0;
                        nmi_queued_q <= nmi_edge;
                        mode_seen_q  <= 1'b0;
                    end
                end
                NMI_ACTIVE: begin
                    if (mode_seen_q && !nmi_mode_i) begin
                        mode_seen_q  <= 1'b0;
                        nmi_queued_q <= 1'b0;
                        if (nmi_queued_q || nmi_edge) begin
                            nmi_state_q <= NMI_PEND;
                            irq_nmi_o   <= 1'b1;
                        end else begin
                            nmi_state_q <= NMI_IDLE;
                        end
                    end else begin
                        if (nmi_mode_i) begin
                            mode_seen_q <= 1'b1;
                        end
                        if (nmi_edge) begin
                            if (nmi_queued_q) begin
                                nmi_lost_o <= 1'b1;
                            end else begin
                                nmi_queued_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    nmi_state_q  <= NMI_IDLE;
                    nmi_queued_q <= 1'b0;
                    mode_seen_q  <= 1'b0;
                    irq_nmi_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule
